// File: rtl/rtc_bus_sequencer.sv
// RTC multiplexed address/data bus sequencer.
// One address phase then one data phase, with programmable setup/strobe/hold timing.
`timescale 1ns/1ps
module rtc_bus_sequencer #(
    parameter int T_SETUP  = 2,
    parameter int T_STROBE = 4,
    parameter int T_HOLD   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_wr,
    input  logic       start_rd,
    input  logic [7:0] addr,
    input  logic [7:0] data_wr,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       ad_sel,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] data_rd,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        A_SETUP,
        A_STROBE,
        A_HOLD,
        D_SETUP,
        D_STROBE,
        D_HOLD,
        DONE
    } state_t;

    state_t     state_q, state_d;
    state_t     nxt;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] ld;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       rd_q, rd_d;
    logic       go;

    logic [7:0] ad_out_q, ad_out_d;
    logic       ad_oe_q, ad_oe_d;
    logic       ad_sel_q, ad_sel_d;
    logic       cs_n_q, cs_n_d;
    logic       wr_n_q, wr_n_d;
    logic       rd_n_q, rd_n_d;
    logic [7:0] data_rd_q, data_rd_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // A start is only honoured once the visible busy flag has dropped too.
    assign go = (start_wr | start_rd) & ~busy_q;

    // State, phase counter and latched transaction registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= 8'd0;
            data_q  <= 8'd0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
        end
    end

    // Next state: timed states advance when the down-counter reaches 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rd_d    = rd_q;
        nxt     = state_q;
        ld      = 8'd0;
        unique case (state_q)
            A_SETUP: begin
                nxt = A_STROBE;
                ld  = 8'(T_STROBE);
            end
            A_STROBE: begin
                nxt = A_HOLD;
                ld  = 8'(T_HOLD);
            end
            A_HOLD: begin
                nxt = D_SETUP;
                ld  = 8'(T_SETUP);
            end
            D_SETUP: begin
                nxt = D_STROBE;
                ld  = 8'(T_STROBE);
            end
            D_STROBE: begin
                nxt = D_HOLD;
                ld  = 8'(T_HOLD);
            end
            D_HOLD: begin
                nxt = DONE;
                ld  = 8'd0;
            end
            IDLE, DONE: begin
                nxt = IDLE;
                ld  = 8'd0;
            end
        endcase
        if (state_q == IDLE) begin
            cnt_d = 8'd0;
            if (go) begin
                state_d = A_SETUP;
                cnt_d   = 8'(T_SETUP);
                addr_d  = addr;
                data_d  = data_wr;
                rd_d    = ~start_wr;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
        end else if (cnt_q <= 8'd1) begin
            state_d = nxt;
            cnt_d   = ld;
        end else begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Output decode from the current state, registered one cycle later.
    always_comb begin
        ad_out_d  = 8'd0;
        ad_oe_d   = 1'b0;
        ad_sel_d  = 1'b0;
        cs_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        rd_n_d    = 1'b1;
        data_rd_d = data_rd_q;
        busy_d    = (state_q != IDLE);
        done_d    = 1'b0;
        if (state_q inside {A_SETUP, A_STROBE, A_HOLD}) begin
            cs_n_d   = 1'b0;
            ad_sel_d = 1'b1;
            ad_oe_d  = 1'b1;
            ad_out_d = addr_q;
            wr_n_d   = (state_q != A_STROBE);
        end
        if (state_q inside {D_SETUP, D_STROBE, D_HOLD}) begin
            cs_n_d = 1'b0;
            if (rd_q) begin
                rd_n_d = (state_q != D_STROBE);
            end else begin
                ad_oe_d  = 1'b1;
                ad_out_d = data_q;
                wr_n_d   = (state_q != D_STROBE);
            end
        end
        if (state_q == DONE) begin
            done_d = 1'b1;
        end
        // Capture read data on the edge where rd_n rises.
        if (!rd_n_q && rd_n_d) begin
            data_rd_d = ad_in;
        end
    end

    // Output registers; reset drives the bus idle immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ad_out_q  <= 8'd0;
            ad_oe_q   <= 1'b0;
            ad_sel_q  <= 1'b0;
            cs_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            data_rd_q <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ad_out_q  <= ad_out_d;
            ad_oe_q   <= ad_oe_d;
            ad_sel_q  <= ad_sel_d;
            cs_n_q    <= cs_n_d;
            wr_n_q    <= wr_n_d;
            rd_n_q    <= rd_n_d;
            data_rd_q <= data_rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ad_out  = ad_out_q;
    assign ad_oe   = ad_oe_q;
    assign ad_sel  = ad_sel_q;
    assign cs_n    = cs_n_q;
    assign wr_n    = wr_n_q;
    assign rd_n    = rd_n_q;
    assign data_rd = data_rd_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: default timing instance plus a 1/1/1 timing instance.
// Stimulus pushes expected transactions; monitors pop and compare on done.
`timescale 1ns/1ps
module tb_rtc_bus_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic       swr_a, srd_a, swr_b, srd_b;
    logic [7:0] addr_a, dwr_a, adin_a, addr_b, dwr_b, adin_b;
    logic [7:0] out_a, drd_a, out_b, drd_b;
    logic       oe_a, sel_a, cs_a, wr_a, rd_a, busy_a, done_a;
    logic       oe_b, sel_b, cs_b, wr_b, rd_b, busy_b, done_b;

    rtc_bus_sequencer dut_a (
        .clk(clk), .reset(reset),
        .start_wr(swr_a), .start_rd(srd_a),
        .addr(addr_a), .data_wr(dwr_a), .ad_in(adin_a),
        .ad_out(out_a), .ad_oe(oe_a), .ad_sel(sel_a),
        .cs_n(cs_a), .wr_n(wr_a), .rd_n(rd_a),
        .data_rd(drd_a), .busy(busy_a), .done(done_a)
    );

    rtc_bus_sequencer #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1)) dut_b (
        .clk(clk), .reset(reset),
        .start_wr(swr_b), .start_rd(srd_b),
        .addr(addr_b), .data_wr(dwr_b), .ad_in(adin_b),
        .ad_out(out_b), .ad_oe(oe_b), .ad_sel(sel_b),
        .cs_n(cs_b), .wr_n(wr_b), .rd_n(rd_b),
        .data_rd(drd_b), .busy(busy_b), .done(done_b)
    );

    typedef struct packed {
        int         done_cyc;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] drd;
        logic       rd;
        int         ts;
        int         tst;
        int         th;
    } exp_t;

    typedef struct packed {
        int wa;
        int wd;
        int rs;
        int bad;
        int cs;
        int last_a;
        int first_d;
    } st_t;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] rdm_a = 8'h00;
    logic [7:0] rdm_b = 8'h00;
    localparam st_t ST0 = '{0, 0, 0, 0, 0, -1, -1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic st_t acc(st_t s, exp_t e, int c, logic wr, logic rd,
                                logic cs, logic sel, logic oe, logic [7:0] o);
        if (!cs) s.cs++;
        if (!wr && !rd) s.bad++;
        if ((!wr || !rd) && cs) s.bad++;
        if (!wr && sel && oe && o == e.addr) begin
            s.wa++;
            s.last_a = c;
        end else if (!wr && !sel && oe && o == e.data && !e.rd) begin
            s.wd++;
            if (s.first_d < 0) s.first_d = c;
        end else if (!rd && !sel && !oe && e.rd) begin
            s.rs++;
            if (s.first_d < 0) s.first_d = c;
        end else if (!wr || !rd) begin
            s.bad++;
        end
        return s;
    endfunction

    task automatic fin(string t, exp_t e, st_t s, int c, logic [7:0] drd);
        chk({t, "_done_cycle"}, c, e.done_cyc);
        chk({t, "_data_rd"}, int'(drd), int'(e.drd));
        chk({t, "_addr_strobe_cycles"}, s.wa, e.tst);
        chk({t, "_wdata_strobe_cycles"}, s.wd, e.rd ? 0 : e.tst);
        chk({t, "_rd_strobe_cycles"}, s.rs, e.rd ? e.tst : 0);
        chk({t, "_cs_low_cycles"}, s.cs, 2 * (e.ts + e.tst + e.th));
        chk({t, "_phase_gap"}, s.first_d - s.last_a, e.th + e.ts + 1);
        chk({t, "_bad_strobe_cycles"}, s.bad, 0);
    endtask

    // Monitor for the default-timing instance.
    st_t sa = ST0;
    always @(negedge clk) begin
        exp_t e;
        e = (qa.size() > 0) ? qa[0] : '0;
        if (reset) begin
            sa = ST0;
        end else begin
            sa = acc(sa, e, cyc, wr_a, rd_a, cs_a, sel_a, oe_a, out_a);
            if (done_a) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_done", 1, 0);
                end else begin
                    e = qa.pop_front();
                    fin("a", e, sa, cyc, drd_a);
                end
                sa = ST0;
            end
        end
    end

    // Monitor for the fast-timing instance.
    st_t sb = ST0;
    always @(negedge clk) begin
        exp_t e;
        e = (qb.size() > 0) ? qb[0] : '0;
        if (reset) begin
            sb = ST0;
        end else begin
            sb = acc(sb, e, cyc, wr_b, rd_b, cs_b, sel_b, oe_b, out_b);
            if (done_b) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_done", 1, 0);
                end else begin
                    e = qb.pop_front();
                    fin("b", e, sb, cyc, drd_b);
                end
                sb = ST0;
            end
        end
    end

    task automatic start_a(logic w, logic r, logic [7:0] a, logic [7:0] d,
                           logic [7:0] ad);
        exp_t e;
        @(negedge clk);
        swr_a = w; srd_a = r; addr_a = a; dwr_a = d; adin_a = ad;
        @(posedge clk);
        #1;
        swr_a = 1'b0; srd_a = 1'b0; addr_a = 8'hFF; dwr_a = 8'hEE;
        e.rd = ~w;
        e.addr = a;
        e.data = d;
        if (e.rd) rdm_a = ad;
        e.drd = rdm_a;
        e.done_cyc = cyc + 17;
        e.ts = 2; e.tst = 4; e.th = 2;
        qa.push_back(e);
    endtask

    task automatic start_b(logic w, logic r, logic [7:0] a, logic [7:0] d,
                           logic [7:0] ad);
        exp_t e;
        @(negedge clk);
        swr_b = w; srd_b = r; addr_b = a; dwr_b = d; adin_b = ad;
        @(posedge clk);
        #1;
        swr_b = 1'b0; srd_b = 1'b0; addr_b = 8'hFF; dwr_b = 8'hEE;
        e.rd = ~w;
        e.addr = a;
        e.data = d;
        if (e.rd) rdm_b = ad;
        e.drd = rdm_b;
        e.done_cyc = cyc + 7;
        e.ts = 1; e.tst = 1; e.th = 1;
        qb.push_back(e);
    endtask

    task automatic idle_a();
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (busy_a && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("a_idle_timeout", int'(busy_a), 0);
    endtask

    task automatic idle_b();
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (busy_b && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("b_idle_timeout", int'(busy_b), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        swr_a = 0; srd_a = 0; addr_a = 0; dwr_a = 0; adin_a = 0;
        swr_b = 0; srd_b = 0; addr_b = 0; dwr_b = 0; adin_b = 0;
        #100;
        chk("rst_cs_n", int'(cs_a), 1);
        chk("rst_wr_n", int'(wr_a), 1);
        chk("rst_rd_n", int'(rd_a), 1);
        chk("rst_ad_oe", int'(oe_a), 0);
        chk("rst_ad_sel", int'(sel_a), 0);
        chk("rst_ad_out", int'(out_a), 0);
        chk("rst_data_rd", int'(drd_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        @(negedge clk);
        reset = 1'b0;

        start_a(1'b1, 1'b0, 8'h21, 8'h15, 8'h00);
        idle_a();
        start_a(1'b0, 1'b1, 8'h22, 8'h00, 8'h43);
        idle_a();
        start_a(1'b1, 1'b0, 8'h24, 8'h99, 8'h43);
        idle_a();

        start_a(1'b1, 1'b0, 8'h25, 8'h66, 8'h43);
        repeat (3) @(negedge clk);
        srd_a = 1'b1;
        @(negedge clk);
        srd_a = 1'b0;
        n = 0;
        while (!done_a && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("a_done_seen", int'(done_a), 1);
        swr_a = 1'b1;
        addr_a = 8'h77;
        @(negedge clk);
        swr_a = 1'b0;
        idle_a();
        repeat (25) @(negedge clk);
        start_a(1'b1, 1'b1, 8'h30, 8'h5A, 8'h10);
        idle_a();

        start_a(1'b1, 1'b0, 8'h26, 8'hC3, 8'h10);
        repeat (11) @(posedge clk);
        #2;
        chk("abort_in_strobe", int'(wr_a), 0);
        reset = 1'b1;
        qa.delete();
        rdm_a = 8'h00;
        rdm_b = 8'h00;
        #1;
        chk("abort_wr_n", int'(wr_a), 1);
        chk("abort_cs_n", int'(cs_a), 1);
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_done", int'(done_a), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        start_a(1'b0, 1'b1, 8'h23, 8'h00, 8'h5C);
        idle_a();

        start_b(1'b1, 1'b0, 8'h11, 8'h22, 8'h00);
        idle_b();
        start_b(1'b0, 1'b1, 8'h12, 8'h00, 8'h99);
        idle_b();

        repeat (5) @(negedge clk);
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
